// File: rtl/ghost_pkg.sv
// Shared types, colour constants and palette lookup for the ghost sprite renderer.
package ghost_pkg;

  typedef enum logic [1:0] {NORMAL, FRIGHT, FLASH} ghost_mode_t;

  localparam logic [23:0] FRIGHT_BLUE = 24'h2121DE;
  localparam logic [23:0] FLASH_WHITE = 24'hDEDEDE;
  localparam logic [23:0] FACE_PEACH  = 24'hFFB8AE;
  localparam logic [23:0] EYE_WHITE   = 24'hDEDEDE;
  localparam logic [23:0] PUPIL_BLUE  = 24'h2121DE;
  localparam logic [23:0] FACE_RED    = 24'hFF0000;

  localparam int unsigned SPRITE_W = 16;
  localparam int unsigned SPRITE_H = 16;

  // Indices 0 and 4..F yield black; opacity is decided separately by the caller.
  function automatic logic [23:0] palette_rgb(input ghost_mode_t mode, input logic flash_phase,
                                              input logic [3:0] idx, input logic [23:0] body);
    logic [23:0] rgb;
    rgb = 24'h000000;
    if (mode == NORMAL) begin
      case (idx)
        4'd1:    rgb = body;
        4'd2:    rgb = EYE_WHITE;
        4'd3:    rgb = PUPIL_BLUE;
        default: rgb = 24'h000000;
      endcase
    end else if (mode == FLASH && flash_phase) begin
      case (idx)
        4'd1:    rgb = FLASH_WHITE;
        4'd2:    rgb = FLASH_WHITE;
        4'd3:    rgb = FACE_RED;
        default: rgb = 24'h000000;
      endcase
    end else begin
      case (idx)
        4'd1:    rgb = FRIGHT_BLUE;
        4'd2:    rgb = FRIGHT_BLUE;
        4'd3:    rgb = FACE_PEACH;
        default: rgb = 24'h000000;
      endcase
    end
    return rgb;
  endfunction

endpackage

// File: rtl/ghost_fright_fsm.sv
// Frightened/flash mode sequencer; counts frames down from FRIGHT_FRAMES and
// toggles the flash colour phase every FLASH_PERIOD frames in the final stretch.
module ghost_fright_fsm
  import ghost_pkg::*;
#(
  parameter int unsigned FRIGHT_FRAMES = 360,
  parameter int unsigned FLASH_FRAMES  = 120,
  parameter int unsigned FLASH_PERIOD  = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        fright_start,
  output ghost_mode_t mode,
  output logic        flash_phase
);

  localparam int unsigned FcntW     = $clog2(FRIGHT_FRAMES + 1);
  localparam int unsigned FlashCntW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;

  localparam logic [FcntW-1:0]     FrightLoad = FcntW'(FRIGHT_FRAMES);
  localparam logic [FcntW-1:0]     FlashLimit = FcntW'(FLASH_FRAMES);
  localparam logic [FlashCntW-1:0] FlashLast  = FlashCntW'(FLASH_PERIOD - 1);

  logic [FcntW-1:0]     fcnt;
  logic [FcntW-1:0]     fcnt_dec;
  logic [FlashCntW-1:0] flash_cnt;

  assign fcnt_dec = fcnt - 1'b1;

  // Reload takes priority over a coincident frame tick.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mode        <= NORMAL;
      fcnt        <= '0;
      flash_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (fright_start) begin
      mode        <= FRIGHT;
      fcnt        <= FrightLoad;
      flash_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (frame_tick) begin
      case (mode)
        FRIGHT: begin
          fcnt <= fcnt_dec;
          if (fcnt_dec <= FlashLimit) mode <= FLASH;
        end
        FLASH: begin
          fcnt <= fcnt_dec;
          if (fcnt_dec == '0) begin
            mode        <= NORMAL;
            flash_cnt   <= '0;
            flash_phase <= 1'b0;
          end else if (flash_cnt == FlashLast) begin
            flash_cnt   <= '0;
            flash_phase <= ~flash_phase;
          end else begin
            flash_cnt <= flash_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ghost_sprite_renderer.sv
// Two-stage ghost sprite pipeline: hit test / ROM address, then palette to RGB.
// Optional frightened mode is compiled in with GHOST_FRIGHT_EN.
module ghost_sprite_renderer
  import ghost_pkg::*;
#(
  parameter int unsigned FRIGHT_FRAMES = 360,
  parameter int unsigned FLASH_FRAMES  = 120,
  parameter int unsigned FLASH_PERIOD  = 8,
  parameter int unsigned ANIM_DIV      = 8,
  parameter logic [23:0] BODY_RGB      = 24'hFF0000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] ghost_x,
  input  logic [9:0] ghost_y,
  input  logic       dir_left,
  input  logic       fright_start,
  output logic [7:0] rom_addr,
  input  logic [3:0] rom_q,
  output logic       pixel_on,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       fright_active
);

  localparam int unsigned AnimW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [AnimW-1:0] AnimLast = AnimW'(ANIM_DIV - 1);

  ghost_mode_t mode;
  logic        flash_phase;

`ifdef GHOST_FRIGHT_EN
  ghost_fright_fsm #(
    .FRIGHT_FRAMES(FRIGHT_FRAMES),
    .FLASH_FRAMES (FLASH_FRAMES),
    .FLASH_PERIOD (FLASH_PERIOD)
  ) u_fright_fsm (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .fright_start(fright_start),
    .mode        (mode),
    .flash_phase (flash_phase)
  );

  assign fright_active = (mode != NORMAL);
`else
  logic unused_fright_start;

  assign unused_fright_start = fright_start;
  assign mode                = NORMAL;
  assign flash_phase         = 1'b0;
  assign fright_active       = 1'b0;
`endif

  // Skirt animation
  logic [AnimW-1:0] anim_cnt;
  logic             anim_phase;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      anim_cnt   <= '0;
      anim_phase <= 1'b0;
    end else if (frame_tick) begin
      if (anim_cnt == AnimLast) begin
        anim_cnt   <= '0;
        anim_phase <= ~anim_phase;
      end else begin
        anim_cnt <= anim_cnt + 1'b1;
      end
    end
  end

  // Stage 1: 11-bit compare so a sprite at the right/bottom edge never wraps to 0.
  logic [10:0] dx_w, dy_w, gx_w, gy_w;
  logic        hit;
  logic [3:0]  rel_x, rel_y, col_base, col;

  assign dx_w = {1'b0, DrawX};
  assign dy_w = {1'b0, DrawY};
  assign gx_w = {1'b0, ghost_x};
  assign gy_w = {1'b0, ghost_y};

  assign hit = (dx_w >= gx_w) && (dx_w < gx_w + 11'(SPRITE_W)) &&
               (dy_w >= gy_w) && (dy_w < gy_w + 11'(SPRITE_H));

  // Low nibble of the difference only depends on the low nibbles.
  assign rel_x    = DrawX[3:0] - ghost_x[3:0];
  assign rel_y    = DrawY[3:0] - ghost_y[3:0];
  assign col_base = dir_left ? (4'hF - rel_x) : rel_x;
  assign col      = (anim_phase && (rel_y >= 4'd13)) ? (col_base ^ 4'hF) : col_base;

  logic hit_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hit_q    <= 1'b0;
      rom_addr <= 8'h00;
    end else begin
      hit_q    <= hit;
      rom_addr <= hit ? {rel_y, col} : 8'h00;
    end
  end

  // Stage 2
  logic        opaque;
  logic [23:0] rgb;

  assign opaque = hit_q && (rom_q != 4'd0) && (rom_q <= 4'd3);
  assign rgb    = palette_rgb(mode, flash_phase, rom_q, BODY_RGB);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pixel_on <= 1'b0;
      red      <= 8'h00;
      green    <= 8'h00;
      blue     <= 8'h00;
    end else begin
      pixel_on <= opaque;
      red      <= opaque ? rgb[23:16] : 8'h00;
      green    <= opaque ? rgb[15:8]  : 8'h00;
      blue     <= opaque ? rgb[7:0]   : 8'h00;
    end
  end

endmodule

// File: tb/tb_ghost_sprite_renderer.sv
// Self-checking bench for ghost_sprite_renderer with a behavioural sprite/mode model.
module tb_ghost_sprite_renderer;
  import ghost_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0, ghost_x = '0, ghost_y = '0;
  logic       dir_left = 1'b0;
  logic       fright_start = 1'b0;
  logic [7:0] rom_addr;
  logic [3:0] rom_q;
  logic       pixel_on;
  logic [7:0] red, green, blue;
  logic       fright_active;

  logic [3:0] rom_mem [256];

  int checks = 0;
  int errors = 0;
  int m_ticks = 0;  // frame ticks since reset
  int m_fcnt = 0;   // remaining fright frames

  assign rom_q = rom_mem[rom_addr];

  always #5 Clk = ~Clk;

  ghost_sprite_renderer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .ghost_x      (ghost_x),
    .ghost_y      (ghost_y),
    .dir_left     (dir_left),
    .fright_start (fright_start),
    .rom_addr     (rom_addr),
    .rom_q        (rom_q),
    .pixel_on     (pixel_on),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .fright_active(fright_active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 normal, 1 fright, 2 flash
  function automatic int m_mode();
    if (m_fcnt == 0) return 0;
    if (m_fcnt > 120) return 1;
    return 2;
  endfunction

  function automatic int m_phase();
    if (m_mode() != 2) return 0;
    return ((120 - m_fcnt) / 8) % 2;
  endfunction

  // Returns 256 + address on a hit, 0 on a miss.
  function automatic int m_addr(input int dx, input int dy, input int gx, input int gy,
                                input bit left);
    int rx, ry, col;
    bit anim;
    anim = ((m_ticks / 8) % 2) == 1;
    if (!(dx >= gx && dx < gx + 16 && dy >= gy && dy < gy + 16)) return 0;
    rx  = dx - gx;
    ry  = dy - gy;
    col = left ? 15 - rx : rx;
    if (anim && ry >= 13) col = 15 - col;
    return 256 + ry * 16 + col;
  endfunction

  function automatic logic [31:0] m_pix(input int hit, input int idx);
    logic [23:0] c;
    if (hit == 0 || idx < 1 || idx > 3) return 32'h0;
    if (m_mode() == 0)
      c = (idx == 1) ? 24'hFF0000 : (idx == 2) ? 24'hDEDEDE : 24'h2121DE;
    else if (m_phase() == 1)
      c = (idx == 3) ? 24'hFF0000 : 24'hDEDEDE;
    else
      c = (idx == 3) ? 24'hFFB8AE : 24'h2121DE;
    return {7'b0, 1'b1, c};
  endfunction

  function automatic logic [31:0] obs_pix();
    return {7'b0, pixel_on, red, green, blue};
  endfunction

  task automatic probe(input int dx, input int dy, input int idx, input string tag);
    int ma;
    @(negedge Clk);
    ma = m_addr(dx, dy, int'(ghost_x), int'(ghost_y), dir_left);
    rom_mem[ma % 256] = 4'(idx);
    DrawX = 10'(dx);
    DrawY = 10'(dy);
    @(negedge Clk);
    check({tag, "_addr"}, {24'b0, rom_addr}, ma % 256);
    @(negedge Clk);
    check({tag, "_pix"}, obs_pix(), m_pix(ma / 256, idx));
  endtask

  task automatic tick(input bit start);
    @(negedge Clk);
    frame_tick   = 1'b1;
    fright_start = start;
    @(negedge Clk);
    frame_tick   = 1'b0;
    fright_start = 1'b0;
    m_ticks++;
`ifdef GHOST_FRIGHT_EN
    if (start) m_fcnt = 360;
    else if (m_fcnt > 0) m_fcnt--;
`endif
  endtask

  task automatic start_pulse();
    @(negedge Clk);
    fright_start = 1'b1;
    @(negedge Clk);
    fright_start = 1'b0;
`ifdef GHOST_FRIGHT_EN
    m_fcnt = 360;
`endif
  endtask

  // Back-to-back random pixels, one per clock, with random ROM contents.
  task automatic stream(input int n, input string tag);
    int a_prev, p1, p2, ma, gx, gy, dx, dy;
    for (int i = 0; i < 256; i++) rom_mem[i] = 4'($urandom_range(0, 15));
    a_prev = 0; p1 = 0; p2 = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      if (i >= 1) check({tag, "_addr"}, {24'b0, rom_addr}, a_prev);
      if (i >= 2) check({tag, "_pix"}, obs_pix(), p2);
      gx = (($urandom_range(0, 7) == 0) ? 1010 : 0) + $urandom_range(0, 13);
      gy = $urandom_range(0, 1000);
      dx = gx + $urandom_range(0, 19) - 2;
      dy = gy + $urandom_range(0, 19) - 2;
      if (dx < 0) dx = 0;
      if (dx > 1023) dx = dx - 1024;
      if (dy < 0) dy = 0;
      ghost_x  = 10'(gx);
      ghost_y  = 10'(gy);
      DrawX    = 10'(dx);
      DrawY    = 10'(dy);
      dir_left = 1'($urandom_range(0, 1));
      ma       = m_addr(dx, dy, gx, gy, dir_left);
      p2       = p1;
      p1       = m_pix(ma / 256, int'(rom_mem[ma % 256]));
      a_prev   = ma % 256;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 4'h0;
    #1;
    check("rst_addr", {24'b0, rom_addr}, 0);
    check("rst_pix", obs_pix(), 0);
    check("rst_fright", {31'b0, fright_active}, 0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    ghost_x = 10'd100; ghost_y = 10'd50; dir_left = 1'b0;
    probe(105, 53, 1, "hit_basic");
    dir_left = 1'b1;
    probe(105, 53, 2, "mirror");
    dir_left = 1'b0;
    probe(116, 53, 1, "miss_right");
    probe(99, 53, 1, "miss_left");
    probe(115, 65, 3, "corner_in");
    probe(105, 66, 1, "miss_below");
    probe(105, 53, 0, "transparent");
    probe(105, 53, 7, "idx_hi");
    ghost_x = 10'd1020;
    probe(3, 53, 1, "no_wrap");
    probe(1023, 53, 2, "edge_hit");
    ghost_x = 10'd100;

    probe(105, 65, 1, "skirt_pre");
    repeat (8) tick(1'b0);
    probe(105, 65, 1, "skirt_post");
    probe(105, 62, 1, "skirt_row12");
    dir_left = 1'b1;
    probe(101, 63, 2, "skirt_mirror");
    dir_left = 1'b0;

    stream(150, "stream_norm");

`ifdef GHOST_FRIGHT_EN
    ghost_x = 10'd100; ghost_y = 10'd50; dir_left = 1'b0;
    DrawX = 10'd0; DrawY = 10'd0;
    start_pulse();
    check("fright_active_on", {31'b0, fright_active}, 1);
    repeat (239) tick(1'b0);
    check("mode_239", {30'b0, dut.mode}, m_mode());
    probe(105, 53, 1, "fright_idx1");
    probe(105, 53, 3, "fright_idx3");
    tick(1'b0);
    check("mode_240", {30'b0, dut.mode}, m_mode());
    probe(105, 53, 1, "flash0_idx1");
    repeat (8) tick(1'b0);
    probe(105, 53, 1, "flash1_idx1");
    probe(105, 53, 3, "flash1_idx3");
    stream(60, "stream_flash");
    repeat (112) tick(1'b0);
    check("mode_360", {30'b0, dut.mode}, m_mode());
    check("fright_active_off", {31'b0, fright_active}, 0);
    ghost_x = 10'd100; ghost_y = 10'd50; dir_left = 1'b0;
    probe(105, 53, 1, "normal_again");

    start_pulse();
    repeat (355) tick(1'b0);
    check("mode_fcnt5", {30'b0, dut.mode}, m_mode());
    tick(1'b1);
    check("mode_reload", {30'b0, dut.mode}, m_mode());
    check("phase_reload", {31'b0, dut.flash_phase}, 0);
    check("fright_active_rl", {31'b0, fright_active}, 1);
    repeat (239) tick(1'b0);
    check("mode_rl_239", {30'b0, dut.mode}, m_mode());
    tick(1'b0);
    check("mode_rl_240", {30'b0, dut.mode}, m_mode());
    repeat (10) tick(1'b0);
    probe(105, 53, 1, "pre_reset");

    #2 Reset = 1'b1;
    #1;
    check("rst_mid_pix", obs_pix(), 0);
    check("rst_mid_addr", {24'b0, rom_addr}, 0);
    check("rst_mid_mode", {30'b0, dut.mode}, 0);
    check("rst_mid_fright", {31'b0, fright_active}, 0);
    m_ticks = 0; m_fcnt = 0;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("post_rst_addr", {24'b0, rom_addr}, m_addr(105, 53, 100, 50, 1'b0) % 256);
    check("post_rst_pix1", obs_pix(), 0);
    @(negedge Clk);
    check("post_rst_pix2", obs_pix(), m_pix(1, 1));
`else
    ghost_x = 10'd100; ghost_y = 10'd50; dir_left = 1'b0;
    start_pulse();
    check("fright_ignored", {31'b0, fright_active}, 0);
    probe(105, 53, 1, "no_fright_idx1");
    tick(1'b1);
    probe(105, 53, 3, "no_fright_idx3");

    probe(105, 53, 2, "pre_reset");
    #2 Reset = 1'b1;
    #1;
    check("rst_mid_pix", obs_pix(), 0);
    check("rst_mid_addr", {24'b0, rom_addr}, 0);
    m_ticks = 0;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("post_rst_addr", {24'b0, rom_addr}, m_addr(105, 53, 100, 50, 1'b0) % 256);
    check("post_rst_pix1", obs_pix(), 0);
    @(negedge Clk);
    check("post_rst_pix2", obs_pix(), m_pix(1, 2));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
